// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, burst-limited sharing of one fifo write port
// Optional per-requester write counters (wrcount) when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] reqdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       accept,
    input  logic                  fifo_full,
    output logic                  fifo_write,
    output logic [WIDTH-1:0]      fifo_datain
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]    wrcount
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [IW-1:0] LAST_INIT  = IW'(NREQ - 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(BURST_MAX - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_n;
    logic [NREQ-1:0] gnt_n;
    logic [IW-1:0]   owner, owner_n, last, last_n, base, pick;
    logic [CW-1:0]   count, count_n;
    logic            pick_valid, xfer, rel;

    assign xfer        = gnt[owner] & req[owner] & ~fifo_full;
    assign fifo_write  = xfer;
    assign accept      = gnt & req & {NREQ{~fifo_full}};
    assign fifo_datain = (|gnt) ? reqdata[int'(owner)*WIDTH +: WIDTH] : '0;

    // Scan starts just after the previous owner, so the owner itself is lowest priority.
    always_comb begin
        base       = (state == OWN) ? owner : last;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(base) + k) % NREQ]) begin
                pick       = IW'((int'(base) + k) % NREQ);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        owner_n = owner;
        last_n  = last;
        count_n = count;
        rel     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = OWN;
                    owner_n = pick;
                    gnt_n   = NREQ'(1) << pick;
                    count_n = '0;
                end
            end
            OWN: begin
                rel = ~req[owner] | (xfer & (count == COUNT_LAST));
                if (rel) begin
                    last_n  = owner;
                    count_n = '0;
                    if (pick_valid) begin
                        owner_n = pick;
                        gnt_n   = NREQ'(1) << pick;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end else if (xfer) begin
                    count_n = count + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            last  <= LAST_INIT;
            count <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            owner <= owner_n;
            last  <= last_n;
            count <= count_n;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] wrcnt [NREQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) wrcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i] && wrcnt[i] != 16'hFFFF) wrcnt[i] <= wrcnt[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_wrcount
        assign wrcount[g*16 +: 16] = wrcnt[g];
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 32;
    localparam int BURST_MAX = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] reqdata = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       accept;
    logic                  fifo_full = 1'b0;
    logic                  fifo_write;
    logic [WIDTH-1:0]      fifo_datain;
`ifdef FIFO_ARB_STATS_EN
    logic [NREQ*16-1:0]    wrcount;
`endif

    fifo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset), .req(req), .reqdata(reqdata), .gnt(gnt),
        .accept(accept), .fifo_full(fifo_full), .fifo_write(fifo_write),
        .fifo_datain(fifo_datain)
`ifdef FIFO_ARB_STATS_EN
        , .wrcount(wrcount)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Round-robin rule: first requester after 'after', wrapping.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r, input int after);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(after + k) % NREQ]) return NREQ'(1) << ((after + k) % NREQ);
        end
        return '0;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] g);
        for (int k = 0; k < NREQ; k++) if (g[k]) return k;
        return 0;
    endfunction

    logic [WIDTH-1:0] exp_q [NREQ][$];
    int wlog_o[$];
    int wlog_c[$];
    int exp_order[$];

    logic [NREQ-1:0] m_exp = '0;
    int m_last = NREQ - 1;
    int m_words = 0;
    int m_o;

    always @(negedge clk) begin
        if (reset) begin
            m_exp   = '0;
            m_last  = NREQ - 1;
            m_words = 0;
        end else begin
            chk("grant", gnt, m_exp);
            chk("accept", accept, gnt & req & {NREQ{~fifo_full}});
            chk("write", fifo_write, |accept);
            if (gnt == '0) chk("idle_data", fifo_datain, '0);
            if (fifo_write) begin
                m_o = oh_idx(gnt);
                if (exp_q[m_o].size() == 0) chk("data_avail", 0, 1);
                else chk("data", fifo_datain, exp_q[m_o].pop_front());
                wlog_o.push_back(m_o);
                wlog_c.push_back(cyc);
                m_words++;
            end
            if (gnt == '0) begin
                m_exp = rr_pick(req, m_last);
            end else begin
                m_o = oh_idx(gnt);
                if (!req[m_o] || m_words == BURST_MAX) begin
                    m_last  = m_o;
                    m_words = 0;
                    m_exp   = rr_pick(req, m_o);
                end else begin
                    m_exp = gnt;
                end
            end
        end
    end

    int              rem [NREQ];
    logic [WIDTH-1:0] dval [NREQ];
    bit              rnd_mode = 1'b0;
    logic [NREQ-1:0] acc;

    task automatic new_word(input int i);
        logic [WIDTH-1:0] d;
        d = rnd_mode ? WIDTH'($urandom) : dval[i];
        reqdata[i*WIDTH +: WIDTH] = d;
        req[i] = 1'b1;
        exp_q[i].push_back(d);
    endtask

    task automatic cycle_drive();
        @(negedge clk);
        acc = accept;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && acc[i]) begin
                rem[i]--;
                if (rem[i] > 0) new_word(i);
                else req[i] = 1'b0;
            end else if (req[i] && rnd_mode && $urandom_range(0, 15) == 0) begin
                req[i] = 1'b0;
                void'(exp_q[i].pop_back());
            end else if (!req[i] && rem[i] > 0 && (!rnd_mode || $urandom_range(0, 3) == 0)) begin
                new_word(i);
            end
        end
        if (rnd_mode) fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    function automatic bit busy();
        for (int i = 0; i < NREQ; i++) if (rem[i] != 0) return 1'b1;
        return (req != '0) || (gnt != '0);
    endfunction

    task automatic wait_idle(input string nm, input int bound);
        int n = 0;
        while (busy() && n < bound) begin
            cycle_drive();
            n++;
        end
        chk({nm, "_done"}, n < bound, 1);
    endtask

    task automatic clear_stim();
        req = '0;
        fifo_full = 1'b0;
        rnd_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            exp_q[i].delete();
        end
    endtask

    task automatic clear_logs();
        wlog_o.delete();
        wlog_c.delete();
        exp_order.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_stim();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic check_log(input string nm, input bit contiguous);
        chk({nm, "_count"}, wlog_o.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < wlog_o.size(); i++)
            chk({nm, "_owner"}, wlog_o[i], exp_order[i]);
        if (contiguous && wlog_c.size() > 0)
            chk({nm, "_gap"}, wlog_c[wlog_c.size()-1] - wlog_c[0], wlog_c.size() - 1);
    endtask

    initial begin
        int n;
        clear_stim();
        req = '1;
        reqdata = {NREQ{32'hDEAD_BEEF}};
        #1;
        chk("rst_gnt", gnt, '0);
        chk("rst_write", fifo_write, 0);
        chk("rst_accept", accept, '0);
        chk("rst_data", fifo_datain, '0);

        // Sole requester, 3 words: bursts of 2 then 1, re-owned with no gap.
        do_reset();
        dval[1] = 32'h11;
        rem[1] = 3;
        exp_order = '{1, 1, 1};
        wait_idle("t1", 50);
        check_log("t1", 1'b1);

        // All requesting: strict rotation, writes back to back.
        do_reset();
        for (int i = 0; i < NREQ; i++) dval[i] = 32'hA000 + i;
        rem[0] = 6; rem[1] = 6; rem[2] = 4; rem[3] = 4;
        for (int t = 0; t < 10; t++) begin
            exp_order.push_back(t % NREQ);
            exp_order.push_back(t % NREQ);
        end
        wait_idle("t2", 100);
        check_log("t2", 1'b1);
`ifdef FIFO_ARB_STATS_EN
        chk("t2_wrcount0", wrcount[0*16 +: 16], 6);
        chk("t2_wrcount1", wrcount[1*16 +: 16], 6);
        chk("t2_wrcount2", wrcount[2*16 +: 16], 4);
        chk("t2_wrcount3", wrcount[3*16 +: 16], 4);
`endif

        // Full stalls the owner without releasing it.
        do_reset();
        fifo_full = 1'b1;
        dval[2] = 32'h2222;
        rem[2] = 2;
        exp_order = '{2, 2};
        for (int c = 0; c < 4; c++) cycle_drive();
        chk("t3_hold_gnt", gnt, 4'b0100);
        chk("t3_no_write", wlog_o.size(), 0);
        fifo_full = 1'b0;
        wait_idle("t3", 50);
        check_log("t3", 1'b1);

        // Owner 0 ends its tenure after one word; requester 3 follows.
        do_reset();
        dval[0] = 32'h0C0C; dval[3] = 32'h3C3C;
        rem[0] = 1; rem[3] = 1;
        exp_order = '{0, 3};
        wait_idle("t4", 50);
        check_log("t4", 1'b0);

        // Reset in the middle of a burst; priority restarts at requester 0 side.
        do_reset();
        dval[1] = 32'h55;
        rem[1] = 3;
        n = 0;
        while (wlog_o.size() == 0 && n < 20) begin
            cycle_drive();
            n++;
        end
        chk("t5_started", wlog_o.size() > 0, 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_gnt", gnt, '0);
        chk("t5_rst_write", fifo_write, 0);
        clear_stim();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        dval[1] = 32'h5151; dval[3] = 32'h5353;
        rem[1] = 1; rem[3] = 1;
        exp_order = '{1, 3};
        wait_idle("t5", 50);
        check_log("t5", 1'b0);

        // Randomized traffic, drops and full; checked by the monitor every cycle.
        do_reset();
        rnd_mode = 1'b1;
        for (int i = 0; i < NREQ; i++) rem[i] = 1000;
        for (int c = 0; c < 2000; c++) cycle_drive();
        rnd_mode = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) rem[i] = req[i] ? 1 : 0;
        wait_idle("t6", 100);
        for (int i = 0; i < NREQ; i++) chk("t6_drained", exp_q[i].size(), 0);

`ifdef FIFO_ARB_STATS_EN
        // Counter saturation after more than 65535 accepts.
        do_reset();
        dval[0] = 32'h1;
        rem[0] = 65540;
        wait_idle("t7", 70000);
        chk("t7_saturate", wrcount[0*16 +: 16], 16'hFFFF);
        chk("t7_other", wrcount[1*16 +: 16], 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
